// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-lite SRAM slave.
//   - AXI response codes and the read/write channel state encodings.
//   - pmem access routines with the same names and argument order as the
//     core's DPI-C pmem entry points (dpic_pmem_read / dpic_pmem_write).
//     Here they act on a sparse behavioural store, so the slave and its
//     bench elaborate without a C harness.
//   - pmem_rd_calls / pmem_wr_calls count every access into the store.
//     Out-of-range accesses, zero-strobe writes and reset-aborted
//     transactions never reach these routines.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  // Sparse word store keyed by word-aligned byte address.
  logic [31:0] pmem [logic [31:0]];
  int unsigned pmem_rd_calls = 0;
  int unsigned pmem_wr_calls = 0;

  function automatic logic [31:0] dpic_pmem_read(input logic [31:0] addr);
    pmem_rd_calls = pmem_rd_calls + 1;
    if (pmem.exists(addr)) return pmem[addr];
    return 32'h0000_0000;
  endfunction

  // Byte-lane merge: only lanes with their strobe bit set are updated.
  function automatic void dpic_pmem_write(input logic [31:0] addr,
                                          input logic [31:0] data,
                                          input logic [3:0]  strb);
    logic [31:0] cur;
    cur = pmem.exists(addr) ? pmem[addr] : 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) cur[8*i +: 8] = data[8*i +: 8];
    end
    pmem[addr] = cur;
    pmem_wr_calls = pmem_wr_calls + 1;
  endfunction

endpackage

// File: rtl/axil_sram_slave_if.sv
// AXI-lite bus bundle between a master (IFU/LSU or bench) and the SRAM slave.
// Ports:
//   read address : araddr, arvalid (m->s), arready (s->m)
//   read data    : rdata, rresp, rvalid (s->m), rready (m->s)
//   write address: awaddr, awvalid (m->s), awready (s->m)
//   write data   : wdata, wstrb, wvalid (m->s), wready (s->m)
//   write resp   : bresp, bvalid (s->m), bready (m->s)
// Modports: slave (memory side), master (requester side).
interface axil_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/sram_lat_cnt.sv
// Loadable down-counter timing the access latency of one slave channel.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (count cleared)
//   load       : load load_val this cycle
//   load_val   : number of wait cycles (>=1) following the load edge
//   done       : high during the last of those wait cycles (one-cycle pulse)
module sram_lat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  // The count reads N in the first wait cycle, so it reads 1 in the Nth.
  assign done = (cnt == ONE);
endmodule

// File: rtl/axil_sram_slave.sv
// AXI-lite memory slave backed by the pmem access routines in axil_pkg.
// Serves as IFU instruction memory and LSU data memory.
// Parameters: ADDR_W, DATA_W (32 only), RD_LAT/WR_LAT (wait cycles >=1),
//   BASE_ADDR/MEM_SIZE (valid byte range [BASE_ADDR, BASE_ADDR+MEM_SIZE)).
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset; aborts any transaction in flight
//   bus   : axil_sram_slave_if.slave (AR/R and AW/W/B channels)
// Read and write channels run independent FSMs with registered handshake
// outputs. Out-of-range accesses answer SLVERR with the normal latency and
// never touch memory.
// Build option: define SRAM_RAND_DELAY_EN to add 0..7 pseudo-random wait
// cycles (8-bit LFSR, x^8+x^6+x^5+x^4+1, seed 8'hA5) to each access.
module axil_sram_slave
  import axil_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                RD_LAT    = 1,
  parameter int                WR_LAT    = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_SIZE  = 'h0800_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  axil_sram_slave_if.slave  bus
);

  if (DATA_W != 32) begin : g_bad_data_w
    $fatal(1, "axil_sram_slave: DATA_W must be 32");
  end
  if (RD_LAT < 1 || WR_LAT < 1) begin : g_bad_lat
    $fatal(1, "axil_sram_slave: RD_LAT and WR_LAT must be >= 1");
  end

  localparam int CNT_W = 16;

  rd_state_t           rd_state;
  wr_state_t           wr_state;
  logic                arready_q, rvalid_q;
  logic                awready_q, wready_q, bvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q, bresp_q;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic                aw_got, w_got;
  logic                ar_hs, aw_hs, w_hs, wr_start;
  logic                rd_done, wr_done, rd_fire, wr_fire;
  logic [2:0]          extra_dly;
  logic [CNT_W-1:0]    rd_load_val, wr_load_val;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    // Subtract first so the check holds even if BASE_ADDR+MEM_SIZE wraps.
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_SIZE);
  endfunction

  function automatic logic [31:0] word_addr(input logic [ADDR_W-1:0] a);
    return 32'({a[ADDR_W-1:2], 2'b00});
  endfunction

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign extra_dly = lfsr[2:0];
`else
  assign extra_dly = 3'd0;
`endif

  // Ready flags are only ever high in the idle states, so these already
  // imply the FSM is idle.
  assign ar_hs    = bus.arvalid && arready_q;
  assign aw_hs    = bus.awvalid && awready_q;
  assign w_hs     = bus.wvalid  && wready_q;
  // Start the write wait on the edge that completes the AW+W pair.
  assign wr_start = (wr_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign rd_fire  = (rd_state == R_WAIT) && rd_done;
  assign wr_fire  = (wr_state == W_WAIT) && wr_done;

  assign rd_load_val = CNT_W'(RD_LAT) + CNT_W'(extra_dly);
  assign wr_load_val = CNT_W'(WR_LAT) + CNT_W'(extra_dly);

  sram_lat_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ar_hs),
    .load_val (rd_load_val),
    .done     (rd_done)
  );

  sram_lat_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wr_start),
    .load_val (wr_load_val),
    .done     (wr_done)
  );

  // Read channel FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_addr   <= bus.araddr;
            arready_q <= 1'b0;
            rd_state  <= R_WAIT;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          if (rd_done) begin
            rvalid_q <= 1'b1;
            rd_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write channel FSM. AW and W are captured independently while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            wr_addr <= bus.awaddr;
            aw_got  <= 1'b1;
          end
          if (w_hs) begin
            wr_data <= bus.wdata;
            wr_strb <= bus.wstrb;
            w_got   <= 1'b1;
          end
          if (wr_start) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wr_state  <= W_WAIT;
          end else begin
            awready_q <= !(aw_got || aw_hs);
            wready_q  <= !(w_got || w_hs);
          end
        end
        W_WAIT: begin
          if (wr_done) begin
            bvalid_q <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Memory access and response registers. The write is issued before the
  // read so a read completing on the same edge observes the new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      if (wr_fire) begin
        if (!in_range(wr_addr)) begin
          bresp_q <= RESP_SLVERR;
        end else begin
          bresp_q <= RESP_OKAY;
          if (wr_strb != '0) dpic_pmem_write(word_addr(wr_addr), wr_data, wr_strb);
        end
      end
      if (rd_fire) begin
        if (in_range(rd_addr)) begin
          rdata_q <= dpic_pmem_read(word_addr(rd_addr));
          rresp_q <= RESP_OKAY;
        end else begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bresp   = bresp_q;
  assign bus.bvalid  = bvalid_q;

endmodule

// File: doc/axil_sram_slave.md
Name: axil_sram_slave

Overview:
- Parametrised AXI-lite memory slave for the simulated core; successor of the single-channel instruction SRAM.
- Serves both read (AR/R) and write (AW/W/B) channels with independent FSMs, configurable access latency and address-range checking.
- Backed by DPI-C pmem calls; used as IFU instruction memory and LSU data memory.

Parameters:
- ADDR_W, 32, address width (AXI_ADDR_BUS).
- DATA_W, 32, data width; only 32 supported, elaboration fatal otherwise.
- RD_LAT, 1, wait cycles between AR handshake and DPI read (>=1).
- WR_LAT, 1, wait cycles between AW+W capture and DPI write (>=1).
- BASE_ADDR, 32'h8000_0000, first valid byte address.
- MEM_SIZE, 32'h0800_0000, valid range size in bytes.

Ports:
- clk in 1: clock.
- rst_n in 1: synchronous active-low reset.
- araddr in ADDR_W; arvalid in 1; arready out 1: read address channel.
- rdata out DATA_W; rresp out 2; rvalid out 1; rready in 1: read data channel.
- awaddr in ADDR_W; awvalid in 1; awready out 1: write address channel.
- wdata in DATA_W; wstrb in DATA_W/8; wvalid in 1; wready out 1: write data channel.
- bresp out 2; bvalid out 1; bready in 1: write response channel.

Behaviour:
- Reset: clock clk; reset rst_n, synchronous, active-low. All FSMs to idle, pending transactions dropped without DPI call, counters cleared. Outputs: arready/awready/wready 0 while rst_n low; rvalid 0, bvalid 0, rdata 0, rresp 2'b00, bresp 2'b00.
- Read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
  - arready = (state==R_IDLE). On arvalid&&arready, araddr is latched and the FSM enters R_WAIT.
  - R_WAIT lasts RD_LAT cycles. On the exiting edge: dpic_pmem_read(latched addr) registered into rdata, rresp set.
  - R_RESP: rvalid=1; rdata/rresp held stable until rready. On rvalid&&rready, to R_IDLE.
  - Latency: handshake in cycle 0 -> rvalid in cycle RD_LAT+1; arready high again the cycle after the R handshake.
- Write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE.
  - W_IDLE: awready = !aw_got; wready = !w_got. AW and W may be captured in either order or in the same cycle.
  - When both are captured (same edge as the last capture), enter W_WAIT for WR_LAT cycles. On the exiting edge: dpic_pmem_write(addr, wdata, wstrb).
  - W_RESP: bvalid=1 until bready; then clear aw_got/w_got and return to W_IDLE.
  - wstrb==0: no DPI call, bresp OKAY.
- Range check: address outside [BASE_ADDR, BASE_ADDR+MEM_SIZE) gives SLVERR (2'b10) with the same latency. No DPI call is made; rdata=0 on such reads.
- Addresses are word-aligned by masking [1:0] before the DPI call.
- Read and write channels are fully concurrent. When both DPI calls fall on the same edge, the write executes first in a single always block, so a read to the same address returns the new data.
- Reset asserted mid-transaction aborts with no response and no DPI side effect.

Optional Feature:
- Macro SRAM_RAND_DELAY_EN.
- Defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) advances every cycle. On each AR or AW+W capture, LFSR[2:0] extra wait cycles (0..7) are added to RD_LAT/WR_LAT.
- Undefined: fixed latency exactly as above; no LFSR logic.

Decomposition:
- Package axil_pkg: resp codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10; enums rd_state_t {R_IDLE,R_WAIT,R_RESP} and wr_state_t {W_IDLE,W_WAIT,W_RESP}; DPI import declarations.
- Sub-module sram_lat_cnt: loadable down-counter with a done pulse, instantiated once per channel. Top module holds the FSMs, range check and DPI calls.

Test Plan:
- RD_LAT=1, pmem[0x80000000]=0x00000413; arvalid with araddr=0x80000000, rready=1 -> rvalid in cycle 2, rdata=0x00000413, rresp=00, arready back high in cycle 3.
- RD_LAT=3, rready held low 5 cycles after rvalid -> rvalid stays 1 and rdata stable throughout; single handshake, no extra DPI read.
- W arrives 2 cycles before AW: wdata=0xDEADBEEF, wstrb=4'b0011, addr 0x80000010 over old 0x11223344 -> bvalid after WR_LAT+1 cycles from the AW handshake; subsequent read returns 0x1122BEEF.
- Read at araddr=0x00001000 -> rresp=2'b10, rdata=0, no DPI call. Write to 0x90000000 -> bresp=2'b10, memory unchanged.
- Concurrent write 0xCAFEBABE (wstrb 4'hF) and read to 0x80000020 finishing on the same edge -> rdata=0xCAFEBABE.
- rst_n pulsed low during R_WAIT -> rvalid never asserted, arready=0 during reset and 1 the cycle after rst_n rises. With SRAM_RAND_DELAY_EN, 100 reads all complete within RD_LAT+8 cycles with correct data.
